fifo_pkt_reader: RTL and testbench
==================================

FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, FIFO and output word width.
REQ-002 SHALL have parameter USEDW_BITS, default 11, width of the FIFO read-side used-word count.
REQ-003 SHALL have parameter PKT_WORDS, default 256, words per packet; legal range 2..2**USEDW_BITS-1.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port enable, input, 1, which permits starting a new packet.
REQ-007 SHALL have port fifo_q, input, WIDTH, FIFO read data, valid in the cycle after fifo_rdreq.
REQ-008 SHALL have port fifo_rdempty, input, 1, FIFO read-side empty flag.
REQ-009 SHALL have port fifo_rdusedw, input, USEDW_BITS, FIFO read-side occupancy.
REQ-010 SHALL have port fifo_rdreq, output, 1, FIFO read strobe.
REQ-011 SHALL have port out_data, output, WIDTH, packet word.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the transfer handshake.
REQ-013 SHALL have ports out_sop and out_eop, output, 1 each, first-word and last-word markers.
REQ-014 SHALL have port pkt_count, output, 16, count of completed packets.
REQ-015 SHALL have port underrun, output, 1, a sticky error flag.

Function
REQ-016 SHALL implement FSM states IDLE and STREAM.
REQ-017 IDLE->STREAM SHALL occur at the edge where enable=1 and fifo_rdusedw>=PKT_WORDS; the read and sent word counters clear to 0.
REQ-018 In STREAM, fifo_rdreq SHALL be high iff reads_issued<PKT_WORDS, fifo_rdempty=0, and (buffer occupancy + words in flight - pop this cycle) < 2.
REQ-019 fifo_q SHALL be written into a 2-entry output buffer at the end of the cycle after fifo_rdreq; the in-flight depth is 1.
REQ-020 out_valid SHALL equal buffer-not-empty, and out_data SHALL be the buffer head.
REQ-021 A transfer SHALL occur iff out_valid and out_ready are both high; out_data and out_valid SHALL hold while out_ready=0.
REQ-022 With the threshold met in cycle c0, fifo_rdreq SHALL rise in c0+1 and out_valid SHALL rise in c0+3.
REQ-023 With out_ready held high, the block SHALL sustain one word per clk.
REQ-024 out_sop SHALL be high with word 0 and out_eop with word PKT_WORDS-1; both SHALL qualify only with out_valid.
REQ-025 On the word-PKT_WORDS-1 transfer, pkt_count SHALL increment modulo 2**16 and the FSM SHALL return to IDLE.
REQ-026 IDLE SHALL evaluate the start condition in the cycle after return, so back-to-back packets have a 1-cycle gap in IDLE.
REQ-027 If fifo_rdempty=1 when a read is otherwise due in STREAM, underrun SHALL set and stay set; the read SHALL stall until data is available.
REQ-028 Deassertion of enable mid-packet SHALL NOT truncate the packet; enable only gates the next start.
REQ-029 fifo_rdreq SHALL never be high in IDLE, and no more than PKT_WORDS reads SHALL issue per packet.

Reset
REQ-030 With reset_n=0 at an edge: state=IDLE, buffer empty, in-flight discarded, counters=0, fifo_rdreq=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, pkt_count=0, underrun=0.
REQ-031 Reset mid-packet SHALL abandon the packet; the partial data is not replayed and no out_eop is issued.

Structure
REQ-032 The FSM state encodings and the default PKT_WORDS=256 (512-byte USB packet) SHALL reside in the shared include/package.
REQ-033 The 2-entry output buffer SHALL be one sub-module, pkt_skid_buf, with a registered head and occupancy count.

Verification
REQ-034 Fill 256 words 0..255 with out_ready=1 -> rdreq at c0+1, out_valid at c0+3, 256 consecutive transfers, sop on 0, eop on 255, pkt_count=1.
REQ-035 Fill 255 words with enable=1 -> stays IDLE with fifo_rdreq=0; the 256th word causes a start.
REQ-036 Hold out_ready=0 for 10 cycles mid-packet -> at most 2 words buffered, fifo_rdreq low, out_data stable, no loss or duplication.
REQ-037 Fill 512 words -> two packets with a 1-cycle IDLE gap, pkt_count=2; drop enable during packet 1 -> packet 1 completes and packet 2 does not start.
REQ-038 Force fifo_rdempty=1 at word 100 for 5 cycles -> underrun=1 and sticky, stream resumes, packet completes with 256 words.
REQ-039 Assert reset_n=0 at word 50 -> next cycle all outputs equal reset values; after refill, the next packet starts with sop and pkt_count=1.

Source files
------------

// File: rtl/fifo_pkt_reader_pkg.sv
// Shared definitions for the FIFO packet reader: FSM states and default sizing.
package fifo_pkt_reader_pkg;

  // Reader FSM: wait for a full packet in the FIFO, then stream it out
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // One 512-byte USB packet of 16-bit words
  localparam int DEFAULT_PKT_WORDS  = 256;
  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_USEDW_BITS = 11;

endpackage

// File: rtl/fifo_pkt_reader_skid_buf.sv
// Two-entry output buffer between the FIFO read port and the packet handshake.
// The head register drives the output data directly; count is the occupancy.
module pkt_skid_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail;

  // Push/pop bookkeeping; the caller never pushes into a full buffer
  // without popping, and never pops an empty one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Reads fixed-size packets out of a dual-clock FIFO read port and presents
// them on a valid/ready stream with start/end-of-packet markers.
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int USEDW_BITS = DEFAULT_USEDW_BITS,
  parameter int PKT_WORDS  = DEFAULT_PKT_WORDS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      fifo_q,
  input  logic                  fifo_rdempty,
  input  logic [USEDW_BITS-1:0] fifo_rdusedw,
  output logic                  fifo_rdreq,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [15:0]           pkt_count,
  output logic                  underrun
);

  localparam logic [USEDW_BITS-1:0] PKT_N    = USEDW_BITS'(PKT_WORDS);
  localparam logic [USEDW_BITS-1:0] PKT_LAST = USEDW_BITS'(PKT_WORDS - 1);

  state_t                state;
  logic [USEDW_BITS-1:0] reads_issued;
  logic [USEDW_BITS-1:0] words_sent;
  logic                  in_flight;
  logic [1:0]            occ;
  logic [2:0]            pending;
  logic                  pop;
  logic                  room;
  logic                  read_due;

  // Words already committed to the buffer (stored or one cycle from the FIFO);
  // a pop this cycle frees a slot, which keeps one word per clock sustained.
  assign pop      = out_valid & out_ready;
  assign pending  = {1'b0, occ} + {2'b00, in_flight};
  assign room     = pending < (3'd2 + {2'b00, pop});
  assign read_due = (state == STREAM) && (reads_issued < PKT_N) && room;

  assign fifo_rdreq = read_due & ~fifo_rdempty;
  assign out_valid  = (occ != 2'd0);
  assign out_sop    = out_valid && (words_sent == '0);
  assign out_eop    = out_valid && (words_sent == PKT_LAST);

  // Packet sequencing, read accounting, completed-packet count and sticky underrun
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      reads_issued <= '0;
      words_sent   <= '0;
      in_flight    <= 1'b0;
      pkt_count    <= 16'd0;
      underrun     <= 1'b0;
    end else begin
      in_flight <= fifo_rdreq;
      if (read_due && fifo_rdempty) underrun <= 1'b1;
      case (state)
        IDLE: begin
          if (enable && (fifo_rdusedw >= PKT_N)) begin
            state        <= STREAM;
            reads_issued <= '0;
            words_sent   <= '0;
          end
        end
        STREAM: begin
          if (fifo_rdreq) reads_issued <= reads_issued + USEDW_BITS'(1);
          if (pop) begin
            words_sent <= words_sent + USEDW_BITS'(1);
            if (words_sent == PKT_LAST) begin
              state     <= IDLE;
              pkt_count <= pkt_count + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pkt_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (in_flight),
    .push_data(fifo_q),
    .pop      (pop),
    .head     (out_data),
    .count    (occ)
  );

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: a queue-based FIFO model feeds the DUT, every
// written word is queued as an expected output (chunked into packets), and a
// negedge monitor pops and compares each transfer.
`timescale 1ns/1ps
module tb_fifo_pkt_reader;

  localparam int W  = 16;
  localparam int UB = 11;
  localparam int P  = 256;

  typedef struct packed {
    logic [W-1:0] d;
    logic         sop;
    logic         eop;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [W-1:0]  fifo_q;
  logic          fifo_rdempty;
  logic [UB-1:0] fifo_rdusedw;
  logic          fifo_rdreq;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic [15:0]   pkt_count;
  logic          underrun;
  logic          force_empty;

  logic [W-1:0] fifo_mem[$];
  exp_t         exp_q[$];
  int fifo_level  = 0;
  int k_written   = 0;
  int reads_total = 0;
  int xfers_total = 0;
  int xfer_in_pkt = 0;
  int pkts_done   = 0;
  int n_checks    = 0;
  int n_fail      = 0;

  always #5 clk = ~clk;

  assign fifo_rdempty = (fifo_level == 0) || force_empty;
  assign fifo_rdusedw = UB'(fifo_level);

  fifo_pkt_reader #(
    .WIDTH(W), .USEDW_BITS(UB), .PKT_WORDS(P)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty), .fifo_rdusedw(fifo_rdusedw),
    .fifo_rdreq(fifo_rdreq), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .pkt_count(pkt_count), .underrun(underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // One clock; the FIFO model returns the requested word in the following cycle
  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = fifo_rdreq;
    @(posedge clk);
    #1;
    if (rd && reset_n) begin
      if (fifo_mem.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL read_from_empty: actual=rdreq high required=no read at %0t", $time);
      end else begin
        fifo_q = fifo_mem.pop_front();
        reads_total++;
      end
      fifo_level = fifo_mem.size();
    end
  endtask

  // Write n words; the k-th word ever written is word k%P of its packet
  task automatic fill(input int n, input bit seq);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d   = seq ? W'(i) : W'($urandom);
      e.sop = (k_written % P) == 0;
      e.eop = (k_written % P) == P - 1;
      fifo_mem.push_back(e.d);
      exp_q.push_back(e);
      k_written++;
    end
    fifo_level = fifo_mem.size();
  endtask

  task automatic run_until(input int target, input bit rnd, input int budget, output int n);
    n = 0;
    while (pkts_done < target && n < budget) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    out_ready = 1'b1;
    if (pkts_done < target) expire("run_until_packet");
  endtask

  task automatic wait_word(input int w, input int budget);
    int n;
    n = 0;
    while (xfer_in_pkt < w && n < budget) begin
      tick();
      n++;
    end
    if (xfer_in_pkt < w) expire("wait_word");
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_rdreq"},    fifo_rdreq, 0);
    chk({pfx, "_valid"},    out_valid,  0);
    chk({pfx, "_sop"},      out_sop,    0);
    chk({pfx, "_eop"},      out_eop,    0);
    chk({pfx, "_data"},     out_data,   0);
    chk({pfx, "_pktcount"}, pkt_count,  0);
    chk({pfx, "_underrun"}, underrun,   0);
  endtask

  // Scoreboard monitor: compares every transfer and the stream invariants
  initial begin : monitor
    exp_t         e;
    logic         stall_prev;
    logic [W-1:0] stall_data;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        xfers_total = 0;
        xfer_in_pkt = 0;
        pkts_done   = 0;
        stall_prev  = 1'b0;
      end else begin
        chk("pkt_count", pkt_count, pkts_done);
        chk("buffered_le2", (reads_total - xfers_total) <= 2, 1);
        if (stall_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, stall_data);
        end
        if (!out_valid) chk("markers_need_valid", {out_sop, out_eop}, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: actual=%0h required=no transfer at %0t", out_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", out_data, e.d);
            chk("word_sop", out_sop, e.sop);
            chk("word_eop", out_eop, e.eop);
            if (e.eop) begin
              pkts_done++;
              xfer_in_pkt = 0;
            end else begin
              xfer_in_pkt++;
            end
          end
          xfers_total++;
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  end

  initial begin : stim
    int n;
    reset_n     = 1'b0;
    enable      = 1'b0;
    out_ready   = 1'b1;
    force_empty = 1'b0;
    fifo_q      = '0;
    tick();
    tick();
    check_reset("por");
    reset_n = 1'b1;
    tick();

    // Single packet of 0..255, latency and full-rate streaming
    fill(256, 1'b1);
    tick();
    enable = 1'b1;
    chk("rdreq_c0", fifo_rdreq, 0);
    tick();
    chk("rdreq_c0p1", fifo_rdreq, 1);
    chk("valid_c0p1", out_valid, 0);
    tick();
    chk("valid_c0p2", out_valid, 0);
    tick();
    chk("valid_c0p3", out_valid, 1);
    chk("sop_c0p3", out_sop, 1);
    run_until(1, 1'b0, 400, n);
    chk("pkt1_cycles", n, 256);
    chk("pkt_count_1", pkt_count, 1);
    enable = 1'b0;

    // One word short of a packet: no start until the last word arrives
    enable = 1'b1;
    fill(255, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("short_rdreq", fifo_rdreq, 0);
      chk("short_valid", out_valid, 0);
    end
    fill(1, 1'b0);
    tick();
    chk("start_on_last_word", fifo_rdreq, 1);
    run_until(2, 1'b1, 3000, n);

    // Back-pressure mid-packet
    fill(256, 1'b0);
    wait_word(100, 600);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_rdreq", fifo_rdreq, 0);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    run_until(3, 1'b0, 600, n);

    // Two queued packets: single idle cycle between them
    fill(512, 1'b0);
    run_until(4, 1'b0, 800, n);
    chk("gap_idle_rdreq", fifo_rdreq, 0);
    chk("gap_idle_valid", out_valid, 0);
    tick();
    chk("gap_restart_rdreq", fifo_rdreq, 1);
    run_until(5, 1'b0, 800, n);

    // Enable dropped during a packet: it completes, the next does not start
    fill(512, 1'b0);
    n = 0;
    while (!fifo_rdreq && n < 50) begin
      tick();
      n++;
    end
    if (!fifo_rdreq) expire("start_before_disable");
    enable = 1'b0;
    run_until(6, 1'b1, 3000, n);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("disabled_rdreq", fifo_rdreq, 0);
      chk("disabled_valid", out_valid, 0);
    end
    chk("pkt_count_6", pkt_count, 6);
    enable = 1'b1;
    run_until(7, 1'b1, 3000, n);

    // FIFO runs dry mid-packet
    fill(256, 1'b0);
    wait_word(100, 600);
    chk("underrun_before", underrun, 0);
    force_empty = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("underrun_set", underrun, 1);
    force_empty = 1'b0;
    run_until(8, 1'b0, 600, n);
    chk("underrun_sticky", underrun, 1);

    // Reset mid-packet abandons it; the FIFO is flushed alongside
    fill(256, 1'b0);
    wait_word(50, 600);
    reset_n = 1'b0;
    fifo_mem.delete();
    exp_q.delete();
    fifo_level  = 0;
    reads_total = 0;
    k_written   = 0;
    tick();
    check_reset("mid_rst");
    tick();
    reset_n = 1'b1;
    tick();
    fill(256, 1'b0);
    run_until(1, 1'b0, 600, n);
    chk("pkt_count_after_reset", pkt_count, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
